uart_xmt_scheduler: RTL

Sequencing and arbitration controller for the UART transmitter. Two byte sources, a request/acknowledge pair each, share one transmitter. The controller grants one source at a time and drives the transmitter's data bus. It issues the load / byte-ready / start strobe sequence, then holds off further grants until the serial frame has had time to finish.

---
 rtl/uart_xmt_scheduler.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_xmt_scheduler.sv
// uart_xmt_scheduler: arbitrates two byte sources onto one UART transmitter,
// then issues the load / byte-ready / start strobes and waits out the frame.
// Build option: define UART_XMT_SCHED_RR_EN for round-robin arbitration;
// otherwise requester 0 has fixed priority.
module uart_xmt_scheduler #(
  parameter int unsigned word_size    = 8,
  parameter int unsigned FRAME_CYCLES = 12
) (
  input  logic                 Clock,
  input  logic                 rst_b,
  input  logic [1:0]           req,
  input  logic [word_size-1:0] data0,
  input  logic [word_size-1:0] data1,
  output logic [1:0]           ack,
  output logic [word_size-1:0] Data_Bus,
  output logic                 Load_XMT_datareg,
  output logic                 Byte_ready,
  output logic                 T_byte,
  output logic                 busy
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READY = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           ack_q, ack_d;
  logic [word_size-1:0] data_q, data_d;
  logic                 load_q, load_d;
  logic                 br_q, br_d;
  logic                 tb_q, tb_d;
  logic                 busy_q, busy_d;
  logic                 win;
`ifdef UART_XMT_SCHED_RR_EN
  logic                 ptr_q, ptr_d;
`endif

  // Next-state, arbitration and registered-output computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 2'b00;
    data_d  = data_q;
    load_d  = 1'b0;
    br_d    = 1'b0;
    tb_d    = 1'b0;
    win     = 1'b0;
`ifdef UART_XMT_SCHED_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
`ifdef UART_XMT_SCHED_RR_EN
          // Pointer only matters when both are requesting
          win   = (req == 2'b11) ? ptr_q : req[1];
          ptr_d = ~win;
`else
          win   = ~req[0];
`endif
          ack_d[win] = 1'b1;
          data_d     = win ? data1 : data0;
          load_d     = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        br_d    = 1'b1;
        state_d = READY;
      end
      READY: begin
        tb_d    = 1'b1;
        state_d = START;
      end
      START: begin
        cnt_d   = CNT_W'(FRAME_CYCLES - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != CNT_W'(0)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge Clock or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 2'b00;
      data_q  <= '0;
      load_q  <= 1'b0;
      br_q    <= 1'b0;
      tb_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      load_q  <= load_d;
      br_q    <= br_d;
      tb_q    <= tb_d;
      busy_q  <= busy_d;
    end
  end

`ifdef UART_XMT_SCHED_RR_EN
  // Round-robin preference pointer
  always_ff @(posedge Clock or negedge rst_b) begin
    if (!rst_b) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign ack              = ack_q;
  assign Data_Bus         = data_q;
  assign Load_XMT_datareg = load_q;
  assign Byte_ready       = br_q;
  assign T_byte           = tb_q;
  assign busy             = busy_q;

endmodule
